apb_master_ctrl: RTL and testbench

APB initiator that converts a simple single-beat request/response interface (from the AHB-side bridge logic) into APB SETUP/ACCESS transfers. It drives the 3-slave APB bus (psel[2:0], penable, pwrite, paddr, pwdata) and captures prdata and status. The block decodes the address to one-hot psel, handles pready wait states, propagates pslverr, and aborts hung transfers with a timeout. Zero-wait slaves without a pready output tie pready=1.

---
 rtl/apb_master_ctrl_if.sv | 45 ++++
 rtl/apb_master_ctrl.sv | 162 ++++++++++++++++
 tb/tb_apb_master_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_ctrl_if.sv
// rtl/apb_master_ctrl_if.sv - request/response and APB bus bundle for apb_master_ctrl
//
// Purpose: groups the single-beat request channel, the response channel and
// the 3-slave APB bus so the controller and its environment share one handle.
// Ports (signals):
//   req_valid/req_ready/req_write/req_addr/req_wdata : request channel
//   rsp_valid/rsp_rdata/rsp_err                      : response channel
//   psel[2:0]/penable/pwrite/paddr/pwdata            : APB initiator outputs
//   prdata/pready/pslverr                            : APB slave returns
// Modports: master = controller view, slave = environment view.
interface apb_master_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [2:0]        psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - APB initiator converting single-beat requests into SETUP/ACCESS transfers
//
// Purpose: accepts one request at a time, decodes the top address byte to a
// one-hot slave select, runs the APB SETUP and ACCESS phases, waits on
// pready, returns read data / slave error as a one-cycle response pulse and
// aborts a transfer that stalls for TIMEOUT ACCESS cycles.
// Ports:
//   hclk   : clock, all state on rising edge
//   hreset : asynchronous active-high reset
//   bus    : apb_master_ctrl_if.master (request, response and APB signals)
// Parameters: ADDR_W (>= 8), DATA_W, TIMEOUT (>= 1).
module apb_master_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 hclk,
  input  logic                 hreset,
  apb_master_ctrl_if.master    bus
);

  // Counter must be able to hold TIMEOUT itself (value after the abort cycle).
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t            state, state_n;
  logic [2:0]        psel_q, psel_n;
  logic              penable_q, penable_n;
  logic              pwrite_q, pwrite_n;
  logic [ADDR_W-1:0] paddr_q, paddr_n;
  logic [DATA_W-1:0] pwdata_q, pwdata_n;
  logic              rsp_valid_q, rsp_valid_n;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_n;
  logic              rsp_err_q, rsp_err_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [2:0]        sel;

  // Slave map lives in the top address byte; anything unmapped yields 0.
  function automatic logic [2:0] decode(input logic [7:0] top);
    logic [2:0] s;
    case (top)
      8'h80:   s = 3'b001;
      8'h84:   s = 3'b010;
      8'h88:   s = 3'b100;
      default: s = 3'b000;
    endcase
    return s;
  endfunction

  assign sel = decode(bus.req_addr[ADDR_W-1 -: 8]);

  always_comb begin
    state_n     = state;
    psel_n      = psel_q;
    penable_n   = penable_q;
    pwrite_n    = pwrite_q;
    paddr_n     = paddr_q;
    pwdata_n    = pwdata_q;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata_q;
    rsp_err_n   = rsp_err_q;
    cnt_n       = cnt_q;

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (sel != 3'b000) begin
            paddr_n   = bus.req_addr;
            pwrite_n  = bus.req_write;
            pwdata_n  = bus.req_wdata;
            psel_n    = sel;
            penable_n = 1'b0;
            cnt_n     = '0;
            state_n   = SETUP;
          end else begin
            // Unmapped address: answer immediately without touching the bus.
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
            rsp_rdata_n = '0;
          end
        end
      end

      SETUP: begin
        penable_n = 1'b1;
        state_n   = ACCESS;
      end

      ACCESS: begin
        if (bus.pready) begin
          psel_n      = 3'b000;
          penable_n   = 1'b0;
          state_n     = IDLE;
          rsp_valid_n = 1'b1;
          rsp_err_n   = bus.pslverr;
          rsp_rdata_n = (!pwrite_q && !bus.pslverr) ? bus.prdata : '0;
        end else begin
          cnt_n = cnt_q + CNT_ONE;
          // This is the TIMEOUT-th stalled ACCESS cycle: give up.
          if (cnt_q == CNT_LAST) begin
            psel_n      = 3'b000;
            penable_n   = 1'b0;
            state_n     = IDLE;
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
            rsp_rdata_n = '0;
          end
        end
      end

      default: begin
        state_n   = IDLE;
        psel_n    = 3'b000;
        penable_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state       <= IDLE;
      psel_q      <= 3'b000;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state       <= state_n;
      psel_q      <= psel_n;
      penable_q   <= penable_n;
      pwrite_q    <= pwrite_n;
      paddr_q     <= paddr_n;
      pwdata_q    <= pwdata_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_rdata_q <= rsp_rdata_n;
      rsp_err_q   <= rsp_err_n;
      cnt_q       <= cnt_n;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - scoreboard bench for apb_master_ctrl
module tb_apb_master_ctrl;
  localparam int TO = 16;

  logic hclk = 1'b0;
  logic hreset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  apb_master_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus.master)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc_cyc;
  } rsp_t;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          waits;
    logic        err;
    logic [31:0] rdata;
    int          acc;
  } apb_t;

  rsp_t exp_q[$];
  apb_t sq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not allowed here", name);
  endtask

  // Reference: what the transfer should do, from the slave map and timeout rule.
  task automatic send(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input int waits, input logic serr, input logic [31:0] rdata);
    int   guard = 0;
    rsp_t r;
    apb_t a;
    logic [31:0] junk;
    while (!bus.req_ready) begin
      // Junk on the request channel while busy must be ignored.
      junk = $urandom();
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_addr  = junk;
      bus.req_write = junk[0];
      bus.req_wdata = ~junk;
      @(negedge hclk);
      guard++;
      if (guard > 100) begin
        fail_evt("req_ready_wait");
        return;
      end
    end
    case (addr[31:24])
      8'h80:   a.sel = 3'b001;
      8'h84:   a.sel = 3'b010;
      8'h88:   a.sel = 3'b100;
      default: a.sel = 3'b000;
    endcase
    r.acc_cyc = cyc + 1;
    if (a.sel == 3'b000) begin
      r.err = 1'b1; r.rdata = 0; r.lat = 0;
    end else begin
      a.addr = addr; a.wr = wr; a.wdata = wdata; a.waits = waits;
      a.err = serr; a.rdata = rdata;
      if (waits >= TO) begin
        a.acc = TO; r.err = 1'b1; r.rdata = 0;
      end else begin
        a.acc = waits + 1; r.err = serr;
        r.rdata = (wr || serr) ? 32'h0 : rdata;
      end
      r.lat = 1 + a.acc;
      sq.push_back(a);
    end
    exp_q.push_back(r);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_write = wr;
    bus.req_wdata = wdata;
    @(negedge hclk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom();
  endtask

  // APB slave model: follows the queued behaviour and checks the bus phases.
  apb_t cur;
  logic active = 1'b0;
  int   acc_n = 0;
  int   wait_left = 0;
  initial begin
    bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;
  end
  always @(negedge hclk) begin
    if (hreset) begin
      active = 1'b0;
      bus.pready = 1'b0;
    end else if (bus.psel != 3'b000) begin
      chk("req_ready_busy", bus.req_ready, 1'b0);
      if (!active) begin
        active = 1'b1;
        acc_n = 0;
        if (sq.size() == 0) begin
          fail_evt("unexpected_psel");
          cur.sel = bus.psel; cur.addr = bus.paddr; cur.wr = bus.pwrite;
          cur.wdata = bus.pwdata; cur.waits = 0; cur.err = 0; cur.rdata = 0; cur.acc = 1;
        end else begin
          cur = sq.pop_front();
        end
        wait_left = cur.waits;
        chk("setup_penable", bus.penable, 1'b0);
      end else begin
        chk("access_penable", bus.penable, 1'b1);
        acc_n++;
        if (wait_left == 0) begin
          bus.pready = 1'b1; bus.pslverr = cur.err; bus.prdata = cur.rdata;
        end else begin
          wait_left--;
          bus.pready = 1'b0; bus.pslverr = 1'($urandom); bus.prdata = $urandom();
        end
      end
      chk("psel", bus.psel, cur.sel);
      chk("paddr", bus.paddr, cur.addr);
      chk("pwrite", bus.pwrite, cur.wr);
      chk("pwdata", bus.pwdata, cur.wdata);
    end else begin
      chk("idle_penable", bus.penable, 1'b0);
      if (active) begin
        chk("access_cycles", acc_n, cur.acc);
        active = 1'b0;
      end
      bus.pready = 1'($urandom); bus.pslverr = 1'($urandom); bus.prdata = $urandom();
    end
  end

  // Response monitor: pops the scoreboard on every rsp_valid.
  rsp_t        me;
  logic        last_err = 1'b0;
  logic [31:0] last_rdata = '0;
  always @(negedge hclk) begin
    if (hreset) begin
      last_err = 1'b0; last_rdata = '0;
    end else if (bus.rsp_valid) begin
      chk("req_ready_at_rsp", bus.req_ready, 1'b1);
      if (exp_q.size() == 0) begin
        fail_evt("rsp_unexpected");
      end else begin
        me = exp_q.pop_front();
        chk("rsp_err", bus.rsp_err, me.err);
        chk("rsp_rdata", bus.rsp_rdata, me.rdata);
        chk("rsp_latency", cyc - me.acc_cyc, me.lat);
      end
      last_err = bus.rsp_err; last_rdata = bus.rsp_rdata;
    end else begin
      chk("rsp_err_hold", bus.rsp_err, last_err);
      chk("rsp_rdata_hold", bus.rsp_rdata, last_rdata);
    end
  end

  initial begin
    int guard;
    logic [31:0] rv;
    logic [7:0]  top;
    int          w;
    int          r2;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(negedge hclk);
    chk("rst_psel", bus.psel, 3'b000);
    chk("rst_penable", bus.penable, 1'b0);
    chk("rst_paddr", bus.paddr, 32'h0);
    chk("rst_pwdata", bus.pwdata, 32'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    hreset = 1'b0;
    @(negedge hclk);

    send(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);   // zero-wait write
    send(32'h8400_0000, 1'b0, 32'h0, 2, 1'b0, 32'd25);          // two wait states
    send(32'h8800_0004, 1'b0, 32'h0, 0, 1'b1, 32'h55);          // slave error
    send(32'h1234_0000, 1'b0, 32'h0, 0, 1'b0, 32'h0);           // decode error
    send(32'h8000_0020, 1'b0, 32'h0, 1000, 1'b0, 32'h0);        // timeout
    send(32'h8400_0030, 1'b0, 32'h0, TO - 1, 1'b0, 32'h1234);   // ready on last cycle

    // Back-to-back: second request must be taken in the first's rsp_valid cycle.
    send(32'h8000_0040, 1'b0, 32'h0, 0, 1'b0, 32'hA5A5_0001);
    guard = 0;
    while (!bus.req_ready && guard < 50) begin @(negedge hclk); guard++; end
    chk("b2b_rsp_valid", bus.rsp_valid, 1'b1);
    send(32'h8800_0044, 1'b1, 32'h0BAD_F00D, 0, 1'b0, 32'h0);

    // Reset in the middle of a stalled ACCESS.
    send(32'h8400_0100, 1'b1, 32'hCAFE_0001, 1000, 1'b0, 32'h0);
    repeat (4) @(negedge hclk);
    chk("pre_rst_penable", bus.penable, 1'b1);
    #2 hreset = 1'b1;
    #1;
    chk("arst_psel", bus.psel, 3'b000);
    chk("arst_penable", bus.penable, 1'b0);
    chk("arst_pwrite", bus.pwrite, 1'b0);
    chk("arst_paddr", bus.paddr, 32'h0);
    chk("arst_pwdata", bus.pwdata, 32'h0);
    chk("arst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("arst_req_ready", bus.req_ready, 1'b1);
    exp_q.delete();
    sq.delete();
    @(negedge hclk);
    @(negedge hclk);
    hreset = 1'b0;
    repeat (5) @(negedge hclk);

    for (int i = 0; i < 150; i++) begin
      rv = $urandom();
      r2 = $urandom_range(0, 9);
      top = (r2 < 3) ? 8'h80 : (r2 < 6) ? 8'h84 : (r2 < 9) ? 8'h88 : rv[31:24];
      r2 = $urandom_range(0, 19);
      w = (r2 < 10) ? 0 : (r2 < 16) ? $urandom_range(1, 4) :
          (r2 < 18) ? TO - 1 : TO + $urandom_range(0, 3);
      send({top, rv[23:0]}, 1'($urandom), $urandom(), w,
           ($urandom_range(0, 3) == 0), $urandom());
      repeat ($urandom_range(0, 2)) @(negedge hclk);
    end

    guard = 0;
    while ((exp_q.size() != 0 || sq.size() != 0) && guard < 300) begin
      @(negedge hclk); guard++;
    end
    if (exp_q.size() != 0 || sq.size() != 0) fail_evt("drain_timeout");
    repeat (3) @(negedge hclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
